// File: rtl/uart_pkg.sv
// Shared definitions for the queued UART transmitter: parity mode codes,
// the serializer state type and the parity helper functions.
package uart_pkg;

    // Run-time parity selection codes; code 3 behaves like PAR_NONE.
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Widest payload the transmitter supports; parity helpers work on this width.
    localparam int MAX_DATA_BITS = 9;

    // Serializer states, in the order they appear on the line.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // True when the mode code asks for a parity bit.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

    // Parity bit for a zero-extended payload. Zero padding does not change
    // the XOR reduction, so narrower payloads can share this function.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0]               mode);
        logic result;
        if (mode == PAR_ODD) begin
            result = ~^data;
        end else begin
            result = ^data;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word (first-word fall-through).
// Storage is an array with a registered read port so it can map to block RAM;
// the head register is refilled from the address that will be the head after
// this edge, with a bypass when that slot is being written in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [LW-1:0]    count_reg;
    logic [LW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == LW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign rd_data = head_reg;

    // A write while full is dropped even if a pop frees a slot this cycle;
    // a flush also drops any concurrent write.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; flush discards everything queued.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + AW'(do_push);
        rd_ptr_next = rd_ptr_reg + AW'(do_pop);
        count_next  = count_reg + LW'(do_push) - LW'(do_pop);
        if (flush) begin
            rd_ptr_next = wr_ptr_reg;
            count_next  = '0;
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage write port.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Registered read of the next head; bypass covers a write into the slot
    // that becomes the head (FIFO empty, or draining its last word).
    always_ff @(posedge clock) begin
        if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= wr_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Queued UART transmitter: a valid/ready write port feeds sync_fifo, and a
// serializer pops words and sends start, data (LSB first), optional parity and
// one or two stop bits. Parity and stop count are latched per word at pop.
// The line output is registered from the current state, so the line trails
// the state register by one cycle; frame_done and tx_busy use the same timing.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 8,
    localparam int LW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic                 tx_clear_req,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_two_stop,
    output logic                 ser_tx,
    output logic                 tx_busy,
    output logic [LW-1:0]        fifo_level,
    output logic                 frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    // FIFO interface
    logic [DATA_BITS-1:0]     fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [MAX_DATA_BITS-1:0] head_ext;

    // Serializer state
    tx_state_e            state_reg;
    tx_state_e            state_next;
    logic [CW-1:0]        cnt_reg;
    logic [CW-1:0]        cnt_next;
    logic [IW-1:0]        idx_reg;
    logic [IW-1:0]        idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 par_en_reg;
    logic                 par_en_next;
    logic                 par_bit_reg;
    logic                 par_bit_next;
    logic                 two_stop_reg;
    logic                 two_stop_next;

    // Registered outputs
    logic                 ser_tx_reg;
    logic                 frame_done_reg;
    logic                 tx_busy_reg;

    logic                 bit_end;
    logic                 frame_end;
    logic                 can_pop;
    logic                 line_bit;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (fifo_pop),
        .flush   (tx_clear_req),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_ready   = !fifo_full;
    assign ser_tx     = ser_tx_reg;
    assign frame_done = frame_done_reg;
    assign tx_busy    = tx_busy_reg;

    // A flush in the same cycle wins over starting a new frame.
    assign can_pop = !fifo_empty && !tx_clear_req;
    assign bit_end = (cnt_reg == CW'(CLKS_PER_BIT - 1));

    // Zero-extend the head word for the shared parity helper.
    always_comb begin
        head_ext                 = '0;
        head_ext[DATA_BITS-1:0]  = fifo_head;
    end

    // Next-state logic: bit timing, state sequencing and word loading.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = bit_end ? '0 : cnt_reg + CW'(1);
        idx_next      = idx_reg;
        shift_next    = shift_reg;
        par_en_next   = par_en_reg;
        par_bit_next  = par_bit_reg;
        two_stop_next = two_stop_reg;
        fifo_pop      = 1'b0;
        frame_end     = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (can_pop) begin
                    fifo_pop   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (idx_reg == IW'(DATA_BITS - 1)) begin
                        idx_next   = '0;
                        state_next = par_en_reg ? PARITY : STOP;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    idx_next   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_stop_reg && (idx_reg == '0)) begin
                        // First of two stop bits done; hold the line high once more.
                        idx_next = IW'(1);
                    end else begin
                        frame_end = 1'b1;
                        idx_next  = '0;
                        if (can_pop) begin
                            // Chain straight into the next frame with no idle gap.
                            fifo_pop   = 1'b1;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase

        // Configuration is sampled only when a word is taken from the FIFO.
        if (fifo_pop) begin
            shift_next    = fifo_head;
            par_en_next   = parity_enabled(cfg_parity);
            par_bit_next  = parity_bit(head_ext, cfg_parity);
            two_stop_next = cfg_two_stop;
        end
    end

    // Line level for the state currently held.
    always_comb begin
        line_bit = 1'b1;
        case (state_reg)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_reg[0];
            PARITY:  line_bit = par_bit_reg;
            default: line_bit = 1'b1;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            two_stop_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            par_en_reg   <= par_en_next;
            par_bit_reg  <= par_bit_next;
            two_stop_reg <= two_stop_next;
        end
    end

    // Output registers: line, end-of-frame pulse and busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            ser_tx_reg     <= 1'b1;
            frame_done_reg <= 1'b0;
            tx_busy_reg    <= 1'b0;
        end else begin
            ser_tx_reg     <= line_bit;
            frame_done_reg <= frame_end;
            tx_busy_reg    <= (state_reg != IDLE) || (fifo_level != '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-waveform model predicts every output on
// every cycle, directed scenarios add literal expectations, then random traffic.
module tb_uart_tx_fifo;

    localparam int DB    = 8;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int LOGN  = 8192;

    typedef bit bitq_t[$];

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_ready;
    logic          tx_clear_req = 1'b0;
    logic [1:0]    cfg_parity = 2'd0;
    logic          cfg_two_stop = 1'b0;
    logic          ser_tx;
    logic          tx_busy;
    logic [LW-1:0] fifo_level;
    logic          frame_done;

    // Second instance: 5-bit payload, two stop bits.
    logic          v5 = 1'b0;
    logic [4:0]    d5 = '0;
    logic          clr5 = 1'b0;
    logic [1:0]    par5 = 2'd0;
    logic          two5 = 1'b1;
    logic          ready5;
    logic          ser5;
    logic          busy5;
    logic [LW-1:0] level5;
    logic          done5;

    always #5 clock = ~clock;

    uart_tx_fifo #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_clear_req(tx_clear_req), .cfg_parity(cfg_parity),
        .cfg_two_stop(cfg_two_stop), .ser_tx(ser_tx), .tx_busy(tx_busy),
        .fifo_level(fifo_level), .frame_done(frame_done)
    );

    uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut5 (
        .clock(clock), .reset(reset), .tx_valid(v5), .tx_data(d5),
        .tx_ready(ready5), .tx_clear_req(clr5), .cfg_parity(par5),
        .cfg_two_stop(two5), .ser_tx(ser5), .tx_busy(busy5),
        .fifo_level(level5), .frame_done(done5)
    );

    int total = 0;
    int passed = 0;
    int cyc = 0;

    // Model state
    int    q[$];
    bit    wave[$];
    int    remaining = 0;
    bit    exp_ser = 1'b1;
    bit    exp_done = 1'b0;
    bit    exp_busy = 1'b0;
    int    exp_level = 0;

    bit log_ser[LOGN];
    bit log_done[LOGN];
    bit log_busy[LOGN];
    int log_level[LOGN];
    bit log5_ser[LOGN];
    bit log5_done[LOGN];
    bit log5_busy[LOGN];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected line level, one entry per clock, for a whole frame.
    function automatic bitq_t make_wave(input int word, input int nbits,
                                        input logic [1:0] par, input bit two);
        bitq_t w;
        bit    bits[$];
        int    ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bits.push_back(bit'((word >> i) & 1));
            ones += (word >> i) & 1;
        end
        if (par == 2'd1) bits.push_back((ones % 2) == 0);
        if (par == 2'd2) bits.push_back((ones % 2) == 1);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < CPB; k++) w.push_back(bits[i]);
        end
        return w;
    endfunction

    // Reference model, advanced on the same edge the DUT samples its inputs.
    always @(posedge clock) begin
        bit in_frame;
        bit fend;
        bit do_pop;
        int sz;
        int w;
        cyc++;
        if (reset) begin
            q.delete();
            wave.delete();
            remaining = 0;
            exp_ser   = 1'b1;
            exp_done  = 1'b0;
            exp_busy  = 1'b0;
        end else begin
            in_frame = (remaining > 0);
            fend     = (remaining == 1);
            exp_busy = in_frame || (q.size() != 0);
            exp_done = fend;
            exp_ser  = in_frame ? wave.pop_front() : 1'b1;
            if (in_frame) remaining--;
            sz     = q.size();
            do_pop = !tx_clear_req && (sz != 0) && (!in_frame || fend);
            if (do_pop) begin
                w         = q.pop_front();
                wave      = make_wave(w, DB, cfg_parity, cfg_two_stop);
                remaining = wave.size();
            end
            if (tx_clear_req) q.delete();
            else if (tx_valid && (sz < DEPTH)) q.push_back(int'(tx_data));
        end
        exp_level = q.size();
    end

    // Compare every output against the model and log traces for directed checks.
    always @(negedge clock) begin
        if (cyc > 0) begin
            check("ser_tx", int'(ser_tx), int'(exp_ser));
            check("frame_done", int'(frame_done), int'(exp_done));
            check("tx_busy", int'(tx_busy), int'(exp_busy));
            check("fifo_level", int'(fifo_level), exp_level);
            check("tx_ready", int'(tx_ready), int'(exp_level != DEPTH));
        end
        if (cyc < LOGN) begin
            log_ser[cyc]   = ser_tx;
            log_done[cyc]  = frame_done;
            log_busy[cyc]  = tx_busy;
            log_level[cyc] = int'(fifo_level);
            log5_ser[cyc]  = ser5;
            log5_done[cyc] = done5;
            log5_busy[cyc] = busy5;
        end
    end

    task automatic push_word(input logic [DB-1:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    function automatic int count_done(input int from, input int to);
        int n;
        n = 0;
        for (int i = from; i <= to; i++) if (i < LOGN && log_done[i]) n++;
        return n;
    endfunction

    initial begin
        bitq_t pw;
        int    w0;
        int    first_low;
        bit    lit1[10]  = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 1};
        bit    lit5[8]   = '{0, 1, 0, 1, 0, 1, 1, 1};
        bit    lita5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        repeat (3) @(negedge clock);
        check("reset_ser", int'(ser_tx), 1);
        check("reset_ready", int'(tx_ready), 1);
        check("reset_busy", int'(tx_busy), 0);
        check("reset_level", int'(fifo_level), 0);
        check("reset_done", int'(frame_done), 0);
        reset = 1'b0;

        // Pin the waveform model to hand-derived frames.
        pw = make_wave(32'h3D, 8, 2'd0, 1'b0);
        check("model_len_3d", pw.size(), 40);
        for (int k = 0; k < 10; k++) check("model_bit_3d", int'(pw[k*CPB]), int'(lit1[k]));
        pw = make_wave(32'h3D, 8, 2'd2, 1'b0);
        check("model_even_3d", int'(pw[36]), 1);
        pw = make_wave(32'h0F, 8, 2'd1, 1'b0);
        check("model_odd_0f", int'(pw[36]), 1);
        check("model_len_par", pw.size(), 44);
        pw = make_wave(32'h15, 5, 2'd0, 1'b1);
        check("model_len_5", pw.size(), 32);

        // Single frame, no parity, one stop bit.
        w0 = cyc + 1;
        push_word(8'h3D);
        repeat (50) @(negedge clock);
        first_low = -1;
        for (int i = w0; i < w0 + 10; i++) if (first_low < 0 && !log_ser[i]) first_low = i;
        check("t1_latency", first_low - w0, 2);
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++)
                check("t1_line", int'(log_ser[w0+2+k*CPB+j]), int'(lit1[k]));
        check("t1_done_count", count_done(w0, w0 + 49), 1);
        check("t1_done_pos", int'(log_done[w0+41]), 1);
        check("t1_busy_last", int'(log_busy[w0+41]), 1);
        check("t1_busy_fall", int'(log_busy[w0+42]), 0);

        // Parity changes between pops; frames back to back.
        cfg_parity = 2'd2;
        w0 = cyc + 1;
        push_word(8'h3D);
        push_word(8'h0F);
        @(negedge clock);
        cfg_parity = 2'd1;
        repeat (100) @(negedge clock);
        check("t2_par1", int'(log_ser[w0+38]), 1);
        check("t2_done1", int'(log_done[w0+45]), 1);
        check("t2_stop1", int'(log_ser[w0+45]), 1);
        check("t2_start2", int'(log_ser[w0+46]), 0);
        check("t2_par2", int'(log_ser[w0+82]), 1);
        check("t2_done2", int'(log_done[w0+89]), 1);
        check("t2_done_count", count_done(w0, w0 + 99), 2);
        cfg_parity = 2'd0;

        // Overfill: 10 writes, tenth dropped, nine frames.
        w0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                check("t3_ready_full", int'(tx_ready), 0);
                check("t3_level_full", int'(fifo_level), 8);
            end
            tx_valid = 1'b1;
            tx_data  = DB'(8'h10 + i);
            @(negedge clock);
        end
        tx_valid = 1'b0;
        repeat (9 * 40 + 20) @(negedge clock);
        check("t3_level_after", log_level[w0+9], 8);
        check("t3_frames", count_done(w0, cyc - 1), 9);

        // Flush with five queued words and a concurrent write.
        w0 = cyc + 1;
        for (int i = 0; i < 6; i++) push_word(DB'(8'h40 + i));
        check("t4_level_before", int'(fifo_level), 5);
        tx_clear_req = 1'b1;
        tx_valid     = 1'b1;
        tx_data      = 8'h77;
        @(negedge clock);
        tx_clear_req = 1'b0;
        tx_valid     = 1'b0;
        check("t4_level_flushed", int'(fifo_level), 0);
        repeat (60) @(negedge clock);
        check("t4_frames", count_done(w0, w0 + 65), 1);
        check("t4_done_pos", int'(log_done[w0+41]), 1);
        check("t4_busy_after", int'(log_busy[w0+42]), 0);

        // Five-bit payload, two stop bits.
        w0 = cyc + 1;
        v5 = 1'b1;
        d5 = 5'h15;
        @(negedge clock);
        v5 = 1'b0;
        repeat (45) @(negedge clock);
        check("t5_idle_before", int'(log5_ser[w0+1]), 1);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < CPB; j++)
                check("t5_line", int'(log5_ser[w0+2+k*CPB+j]), int'(lit5[k]));
        check("t5_done_pos", int'(log5_done[w0+33]), 1);
        check("t5_done_early", int'(log5_done[w0+29]), 0);
        check("t5_busy_last", int'(log5_busy[w0+33]), 1);
        check("t5_busy_fall", int'(log5_busy[w0+34]), 0);

        // Reset in the middle of DATA bit 3, then a clean frame.
        w0 = cyc + 1;
        push_word(8'hFF);
        push_word(8'h11);
        repeat (w0 + 18 - cyc) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_ser", int'(ser_tx), 1);
        check("t6_level", int'(fifo_level), 0);
        check("t6_busy", int'(tx_busy), 0);
        w0 = cyc + 1;
        push_word(8'hA5);
        repeat (50) @(negedge clock);
        for (int k = 0; k < 10; k++) check("t6_line", int'(log_ser[w0+2+k*CPB+1]), int'(lita5[k]));
        check("t6_done_pos", int'(log_done[w0+41]), 1);

        // Random traffic with run-time configuration, flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            tx_valid     = ($urandom_range(0, 99) < 40);
            tx_data      = DB'($urandom);
            tx_clear_req = ($urandom_range(0, 499) == 0);
            reset        = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 49) == 0) begin
                cfg_parity   = 2'($urandom_range(0, 3));
                cfg_two_stop = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
        end
        tx_valid     = 1'b0;
        tx_clear_req = 1'b0;
        reset        = 1'b0;
        repeat (600) @(negedge clock);
        check("drain_busy", int'(tx_busy), 0);
        check("drain_level", int'(fifo_level), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
